exc_report_unit: RTL and testbench

- Pipeline-side producer of the exception report consumed by the coprocessor-0 block.
- Collects raw per-instruction exception flags from the memory stage and prioritises them into one ExcCode with its PC, BadVAddr, delay-slot bit and ERET flag.
- Holds that report until CP0 accepts it.
- On CP0's exc_occur (exception or interrupt), runs a flush/redirect sequence toward fetch.

---
 rtl/exc_report_unit.sv | 165 ++++++++++++++++
 tb/tb_exc_report_unit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/exc_report_unit.sv
// Exception report producer: prioritises memory-stage exception flags into a CP0 report and runs flush/redirect.
// Optional EXC_REPORT_COUNT_EN adds exc_count, a running count of taken exceptions and interrupts.
module exc_report_unit #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic        in_is_in_ds,
    input  logic        in_fetch_adel,
    input  logic        in_ri,
    input  logic        in_sys,
    input  logic        in_bp,
    input  logic        in_ov,
    input  logic        in_load_adel,
    input  logic        in_store_ades,
    input  logic        in_eret,
    input  logic [31:0] in_mem_addr,
    output logic [31:0] pre_pc,
    output logic [31:0] pre_badvaddr,
    output logic [4:0]  pre_excCode,
    output logic        pre_is_exc,
    output logic        pre_is_in_ds,
    output logic        pre_is_eret,
    input  logic        cp0_reg_valid,
    input  logic        cp0_exc_occur,
    input  logic [31:0] cp0_pc,
    input  logic        iram_stall,
    output logic        flush_all,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
`ifdef EXC_REPORT_COUNT_EN
    output logic [31:0] exc_count,
`endif
    input  logic        redirect_ready
);

    typedef enum logic [1:0] {IDLE, REPORT, FLUSH, REDIRECT} state_t;

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    function automatic logic [4:0] exc_code_f(
        input logic fa, input logic ri, input logic ov, input logic sys,
        input logic bp, input logic la, input logic sa);
        logic [4:0] code;
        if (fa)       code = 5'd4;
        else if (ri)  code = 5'd10;
        else if (ov)  code = 5'd12;
        else if (sys) code = 5'd8;
        else if (bp)  code = 5'd9;
        else if (la)  code = 5'd4;
        else if (sa)  code = 5'd5;
        else          code = 5'd0;
        return code;
    endfunction

    // BadVAddr follows the winning cause, so a higher-priority non-address cause yields 0.
    function automatic logic [31:0] badvaddr_f(
        input logic fa, input logic ri, input logic ov, input logic sys,
        input logic bp, input logic la, input logic sa,
        input logic [31:0] pc, input logic [31:0] addr);
        logic [31:0] va;
        if (fa)                     va = pc;
        else if (ri | ov | sys | bp) va = 32'd0;
        else if (la | sa)           va = addr;
        else                        va = 32'd0;
        return va;
    endfunction

    function automatic logic [31:0] redirect_target_f(input logic [31:0] pc);
        return (pc[1:0] != 2'b00) ? EXC_VECTOR : pc;
    endfunction

    state_t      state;
    logic [3:0]  flush_cnt;
    logic [31:0] cap_pc_p1;
    logic        any_flag;
    logic        any_exc;
    logic        take_flush;

    assign any_flag   = in_fetch_adel | in_ri | in_sys | in_bp | in_ov | in_load_adel | in_store_ades;
    // An interrupt in IDLE pre-empts the presented instruction, so it is refused combinationally.
    assign in_ready   = (state == IDLE) & ~(cp0_exc_occur & cp0_reg_valid);
    assign any_exc    = in_valid & in_ready & (any_flag | in_eret);
    assign take_flush = ((state == IDLE) | (state == REPORT)) & cp0_reg_valid & cp0_exc_occur;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state          <= IDLE;
            flush_cnt      <= 4'd0;
            cap_pc_p1      <= 32'd0;
            pre_pc         <= 32'd0;
            pre_badvaddr   <= 32'd0;
            pre_excCode    <= 5'd0;
            pre_is_exc     <= 1'b0;
            pre_is_in_ds   <= 1'b0;
            pre_is_eret    <= 1'b0;
            flush_all      <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (take_flush) begin
                        cap_pc_p1 <= cp0_pc;
                        flush_all <= 1'b1;
                        flush_cnt <= FLUSH_LOAD;
                        state     <= FLUSH;
                    end else if (any_exc) begin
                        pre_pc       <= in_pc;
                        pre_is_in_ds <= in_is_in_ds;
                        pre_is_eret  <= in_eret & ~any_flag;
                        pre_excCode  <= exc_code_f(in_fetch_adel, in_ri, in_ov, in_sys,
                                                   in_bp, in_load_adel, in_store_ades);
                        pre_badvaddr <= badvaddr_f(in_fetch_adel, in_ri, in_ov, in_sys,
                                                   in_bp, in_load_adel, in_store_ades,
                                                   in_pc, in_mem_addr);
                        pre_is_exc   <= 1'b1;
                        state        <= REPORT;
                    end
                end
                REPORT: begin
                    if (take_flush) begin
                        cap_pc_p1  <= cp0_pc;
                        pre_is_exc <= 1'b0;
                        flush_all  <= 1'b1;
                        flush_cnt  <= FLUSH_LOAD;
                        state      <= FLUSH;
                    end else if (cp0_reg_valid) begin
                        pre_is_exc <= 1'b0;
                        state      <= IDLE;
                    end
                end
                FLUSH: begin
                    if (flush_cnt == 4'd0) begin
                        flush_all      <= 1'b0;
                        redirect_valid <= 1'b1;
                        redirect_pc    <= redirect_target_f(cap_pc_p1);
                        state          <= REDIRECT;
                    end else begin
                        flush_cnt <= flush_cnt - 4'd1;
                    end
                end
                REDIRECT: begin
                    if (redirect_valid & redirect_ready & ~iram_stall) begin
                        redirect_valid <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef EXC_REPORT_COUNT_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)         exc_count <= 32'd0;
        else if (take_flush) exc_count <= exc_count + 32'd1;
    end
`endif

endmodule

// File: tb/tb_exc_report_unit.sv
// Directed self-checking bench for exc_report_unit with hand-computed expectations.
`timescale 1ns/1ps
module tb_exc_report_unit;

    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid, in_ready;
    logic [31:0] in_pc, in_mem_addr;
    logic        in_is_in_ds, in_fetch_adel, in_ri, in_sys, in_bp, in_ov;
    logic        in_load_adel, in_store_ades, in_eret;
    logic [31:0] pre_pc, pre_badvaddr;
    logic [4:0]  pre_excCode;
    logic        pre_is_exc, pre_is_in_ds, pre_is_eret;
    logic        cp0_reg_valid, cp0_exc_occur;
    logic [31:0] cp0_pc;
    logic        iram_stall, flush_all, redirect_valid, redirect_ready;
    logic [31:0] redirect_pc;
`ifdef EXC_REPORT_COUNT_EN
    logic [31:0] exc_count;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    exc_report_unit dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_is_in_ds(in_is_in_ds), .in_fetch_adel(in_fetch_adel), .in_ri(in_ri),
        .in_sys(in_sys), .in_bp(in_bp), .in_ov(in_ov), .in_load_adel(in_load_adel),
        .in_store_ades(in_store_ades), .in_eret(in_eret), .in_mem_addr(in_mem_addr),
        .pre_pc(pre_pc), .pre_badvaddr(pre_badvaddr), .pre_excCode(pre_excCode),
        .pre_is_exc(pre_is_exc), .pre_is_in_ds(pre_is_in_ds), .pre_is_eret(pre_is_eret),
        .cp0_reg_valid(cp0_reg_valid), .cp0_exc_occur(cp0_exc_occur), .cp0_pc(cp0_pc),
        .iram_stall(iram_stall), .flush_all(flush_all),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
`ifdef EXC_REPORT_COUNT_EN
        .exc_count(exc_count),
`endif
        .redirect_ready(redirect_ready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        in_valid = 0; in_pc = 0; in_mem_addr = 0; in_is_in_ds = 0;
        in_fetch_adel = 0; in_ri = 0; in_sys = 0; in_bp = 0; in_ov = 0;
        in_load_adel = 0; in_store_ades = 0; in_eret = 0;
    endtask

    // Present one instruction for one cycle; report becomes visible after the edge.
    task automatic present(input logic [31:0] pc, input logic [31:0] addr, input logic [7:0] flags);
        in_valid = 1; in_pc = pc; in_mem_addr = addr;
        {in_eret, in_fetch_adel, in_ri, in_ov, in_sys, in_bp, in_load_adel, in_store_ades} = flags;
        tick();
        clear_inputs();
    endtask

    // CP0 samples the report and drops it without taking it.
    task automatic drop_report();
        cp0_reg_valid = 1; cp0_exc_occur = 0;
        tick();
        cp0_reg_valid = 0;
    endtask

    int fcnt;
    logic [31:0] held_pc;

    initial begin
        clear_inputs();
        cp0_reg_valid = 0; cp0_exc_occur = 0; cp0_pc = 0;
        iram_stall = 0; redirect_ready = 0;
        resetn = 0;
        #12;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_pre_is_exc", {31'd0, pre_is_exc}, 32'd0);
        check("rst_flush", {31'd0, flush_all}, 32'd0);
        check("rst_redir", {31'd0, redirect_valid}, 32'd0);
        check("rst_code", {27'd0, pre_excCode}, 32'd0);
        tick();
        resetn = 1;
        tick();

        // flag order: eret, fetch_adel, ri, ov, sys, bp, load_adel, store_ades
        in_is_in_ds = 1;
        present(32'h80001004, 32'h80002001, 8'b0000_0010);
        check("ld_is_exc", {31'd0, pre_is_exc}, 32'd1);
        check("ld_code", {27'd0, pre_excCode}, 32'd4);
        check("ld_badva", pre_badvaddr, 32'h80002001);
        check("ld_pc", pre_pc, 32'h80001004);
        check("ld_ds", {31'd0, pre_is_in_ds}, 32'd1);
        check("ld_ready", {31'd0, in_ready}, 32'd0);
        drop_report();
        check("drop_is_exc", {31'd0, pre_is_exc}, 32'd0);
        check("drop_ready", {31'd0, in_ready}, 32'd1);

        present(32'h80000002, 32'h00001234, 8'b0101_0000);
        check("fa_ov_code", {27'd0, pre_excCode}, 32'd4);
        check("fa_ov_badva", pre_badvaddr, 32'h80000002);
        drop_report();
        present(32'h80000010, 32'h00001234, 8'b0010_1000);
        check("ri_sys_code", {27'd0, pre_excCode}, 32'd10);
        check("ri_sys_badva", pre_badvaddr, 32'd0);
        drop_report();
        present(32'h80000020, 32'h00000000, 8'b0000_1100);
        check("sys_bp_code", {27'd0, pre_excCode}, 32'd8);
        drop_report();
        present(32'h80000024, 32'h80003002, 8'b0000_0001);
        check("st_code", {27'd0, pre_excCode}, 32'd5);
        check("st_badva", pre_badvaddr, 32'h80003002);
        drop_report();

        // Overflow report held five cycles, then taken.
        present(32'h80000030, 32'h0, 8'b0001_0000);
        check("ov_code", {27'd0, pre_excCode}, 32'd12);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_is_exc", {31'd0, pre_is_exc}, 32'd1);
            check("hold_pc", pre_pc, 32'h80000030);
        end
        cp0_reg_valid = 1; cp0_exc_occur = 1; cp0_pc = 32'hBFC00380;
        tick();
        cp0_reg_valid = 0; cp0_exc_occur = 0; cp0_pc = 0;
        check("take_is_exc", {31'd0, pre_is_exc}, 32'd0);
        fcnt = flush_all ? 1 : 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (flush_all) fcnt++;
            else break;
        end
        check("flush_len", fcnt, 32'd2);
        check("redir_valid", {31'd0, redirect_valid}, 32'd1);
        check("redir_pc", redirect_pc, 32'hBFC00380);
        redirect_ready = 1; iram_stall = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_valid", {31'd0, redirect_valid}, 32'd1);
            check("stall_pc", redirect_pc, 32'hBFC00380);
        end
        iram_stall = 0;
        tick();
        redirect_ready = 0;
        check("done_valid", {31'd0, redirect_valid}, 32'd0);
        check("done_ready", {31'd0, in_ready}, 32'd1);

        // ERET dropped by CP0: no flush.
        present(32'h80000040, 32'h0, 8'b1000_0000);
        check("eret_flag", {31'd0, pre_is_eret}, 32'd1);
        check("eret_code", {27'd0, pre_excCode}, 32'd0);
        drop_report();
        check("eret_noflush", {31'd0, flush_all}, 32'd0);
        tick();
        check("eret_noflush2", {31'd0, flush_all}, 32'd0);
        check("eret_ready", {31'd0, in_ready}, 32'd1);

        // Misaligned CP0 target falls back to the vector.
        present(32'h80000050, 32'h0, 8'b0000_1000);
        cp0_reg_valid = 1; cp0_exc_occur = 1; cp0_pc = 32'h80000003;
        tick();
        cp0_reg_valid = 0; cp0_exc_occur = 0; cp0_pc = 0;
        fcnt = 0;
        while (!redirect_valid && fcnt < 20) begin
            tick();
            fcnt++;
        end
        check("misal_reached", {31'd0, redirect_valid}, 32'd1);
        check("misal_pc", redirect_pc, 32'hBFC00380);
        held_pc = redirect_pc;
        redirect_ready = 1;
        tick();
        redirect_ready = 0;
        check("misal_done", {31'd0, redirect_valid}, 32'd0);

        // Interrupt collides with an excepting instruction in IDLE.
        in_valid = 1; in_bp = 1; in_pc = 32'h80000060;
        cp0_reg_valid = 1; cp0_exc_occur = 1; cp0_pc = 32'h80000180;
        #1;
        check("coll_ready", {31'd0, in_ready}, 32'd0);
        tick();
        clear_inputs();
        cp0_reg_valid = 0; cp0_exc_occur = 0; cp0_pc = 0;
        check("coll_is_exc", {31'd0, pre_is_exc}, 32'd0);
        check("coll_flush", {31'd0, flush_all}, 32'd1);
`ifdef EXC_REPORT_COUNT_EN
        check("exc_count", exc_count, 32'd3);
`endif
        // Asynchronous reset in the middle of FLUSH.
        #2;
        resetn = 0;
        #1;
        check("arst_flush", {31'd0, flush_all}, 32'd0);
        check("arst_redir", {31'd0, redirect_valid}, 32'd0);
        check("arst_ready", {31'd0, in_ready}, 32'd1);
`ifdef EXC_REPORT_COUNT_EN
        check("arst_count", exc_count, 32'd0);
`endif
        tick();
        resetn = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post_rst_redir", {31'd0, redirect_valid}, 32'd0);
            check("post_rst_flush", {31'd0, flush_all}, 32'd0);
        end
        check("post_rst_ready", {31'd0, in_ready}, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
